// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display frame read scheduler.
// Buffer base table is built by repeated addition so no multiplier is inferred.
package display_sched_pkg;

    localparam int unsigned DEF_FRAME_WIDTH     = 540;
    localparam int unsigned DEF_FRAME_HEIGHT    = 540;
    localparam int unsigned DEF_NUM_BUFS        = 3;
    localparam int unsigned DEF_MAX_OUTSTANDING = 2;

    localparam int unsigned LINE_BEATS      = DEF_FRAME_WIDTH / 2;
    localparam int unsigned LINE_BYTES      = DEF_FRAME_WIDTH * 4;
    localparam int unsigned DEF_FRAME_BYTES = LINE_BYTES * DEF_FRAME_HEIGHT;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned LINE_CNT_W  = 12;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned BUF_IDX_W   = 2;
    localparam int unsigned CREDIT_W    = 3;
    localparam int unsigned MAX_BUFS    = 4;

    typedef logic [MAX_BUFS-1:0][ADDR_W-1:0] buf_table_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitCredit,
        StDrain
    } sched_state_e;

    function automatic buf_table_t buf_base_table(logic [ADDR_W-1:0] base,
                                                  logic [ADDR_W-1:0] stride);
        buf_table_t t;
        t[0] = base;
        t[1] = t[0] + stride;
        t[2] = t[1] + stride;
        t[3] = t[2] + stride;
        return t;
    endfunction

    localparam buf_table_t BUF_BASE = buf_base_table(32'h0000_0000, DEF_FRAME_BYTES);

endpackage

// File: rtl/display_frame_read_sched_if.sv
// DMA read command channel plus line-completion return.
interface display_frame_read_sched_if;
    import display_sched_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              line_done;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready,
        input  line_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready,
        output line_done
    );

endinterface

// File: rtl/display_sched_credit_cnt.sv
// Outstanding-line counter: up on command handshake, down on line completion.
// Never underflows on a stray line_done and never counts past MAX_OUTSTANDING.
module display_sched_credit_cnt
    import display_sched_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic credit_ok,
    output logic cnt_zero
);

    logic [CREDIT_W-1:0] count_q, count_d;
    logic                inc_ok, dec_ok;

    assign inc_ok = inc && (32'(count_q) < MAX_OUTSTANDING);
    assign dec_ok = dec && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (inc_ok && !dec_ok) begin
            count_d = count_q + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign credit_ok = 32'(count_q) < MAX_OUTSTANDING;
    assign cnt_zero  = (count_q == '0);

endmodule

// File: rtl/display_frame_read_sched.sv
// Frame-synchronous display DMA read scheduler: one read command per line of the
// most recently completed frame buffer, gated by line credits and FIFO space.
module display_frame_read_sched
    import display_sched_pkg::*;
#(
    parameter int unsigned     FRAME_WIDTH     = DEF_FRAME_WIDTH,
    parameter int unsigned     FRAME_HEIGHT    = DEF_FRAME_HEIGHT,
    parameter logic [31:0]     BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned     FRAME_BYTES     = FRAME_WIDTH * FRAME_HEIGHT * 4,
    parameter int unsigned     NUM_BUFS        = DEF_NUM_BUFS,
    parameter int unsigned     MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       frame_start,
    input  logic                       wr_buf_valid,
    input  logic [BUF_IDX_W-1:0]       wr_buf_idx,
    input  logic                       space_ok,
    display_frame_read_sched_if.master dma,
    output logic                       busy,
    output logic [BUF_IDX_W-1:0]       rd_buf_idx,
    output logic [LINE_CNT_W-1:0]      line_cnt,
    output logic [FRAME_CNT_W-1:0]     frame_cnt,
    output logic                       err_frame_late,
    output logic                       err_no_buffer
);

    localparam buf_table_t              BASE_TAB    = buf_base_table(BASE_ADDR,
                                                                     32'(FRAME_BYTES));
    localparam logic [ADDR_W-1:0]       LINE_STRIDE = 32'(FRAME_WIDTH * 4);
    localparam logic [LEN_W-1:0]        LINE_LEN    = 16'(FRAME_WIDTH / 2);
    localparam logic [LINE_CNT_W-1:0]   LAST_LINE   = 12'(FRAME_HEIGHT - 1);

    sched_state_e             state_q;
    logic                     cmd_valid_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     busy_q;
    logic [BUF_IDX_W-1:0]     rd_buf_idx_q;
    logic [LINE_CNT_W-1:0]    line_cnt_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic                     err_frame_late_q;
    logic                     err_no_buffer_q;

    logic handshake;
    logic credit_ok;
    logic cnt_zero;
    logic buf_ok;

    assign handshake = cmd_valid_q && dma.cmd_ready;
    assign buf_ok    = wr_buf_valid && (32'(wr_buf_idx) < NUM_BUFS);

    display_sched_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (handshake),
        .dec       (dma.line_done),
        .credit_ok (credit_ok),
        .cnt_zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            cmd_valid_q      <= 1'b0;
            addr_q           <= '0;
            busy_q           <= 1'b0;
            rd_buf_idx_q     <= '0;
            line_cnt_q       <= '0;
            frame_cnt_q      <= '0;
            err_frame_late_q <= 1'b0;
            err_no_buffer_q  <= 1'b0;
        end else begin
            // Any non-idle state counts as busy, including the DRAIN exit cycle.
            if (frame_start && (state_q != StIdle)) begin
                err_frame_late_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (frame_start && enable) begin
                        if (buf_ok) begin
                            rd_buf_idx_q <= wr_buf_idx;
                            addr_q       <= BASE_TAB[wr_buf_idx];
                            line_cnt_q   <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= StIssue;
                        end else begin
                            err_no_buffer_q <= 1'b1;
                        end
                    end
                end

                StIssue, StWaitCredit: begin
                    if (cmd_valid_q) begin
                        // Command stays frozen until accepted.
                        if (dma.cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            addr_q      <= addr_q + LINE_STRIDE;
                            line_cnt_q  <= line_cnt_q + 1'b1;
                            if (line_cnt_q == LAST_LINE) begin
                                state_q <= StDrain;
                            end
                        end
                    end else if (credit_ok && space_ok) begin
                        cmd_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end else begin
                        state_q <= StWaitCredit;
                    end
                end

                StDrain: begin
                    if (cnt_zero) begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign dma.cmd_valid  = cmd_valid_q;
    assign dma.cmd_addr   = addr_q;
    assign dma.cmd_len    = LINE_LEN;
    assign busy           = busy_q;
    assign rd_buf_idx     = rd_buf_idx_q;
    assign line_cnt       = line_cnt_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_frame_late = err_frame_late_q;
    assign err_no_buffer  = err_no_buffer_q;

endmodule

// File: doc/display_frame_read_sched.md
Name: display_frame_read_sched

Overview:
- Frame-synchronous DMA read scheduler for the display path.
- On each display frame start it picks the most recently completed frame buffer.
- It then issues one DMA read command per image line. Issue is gated by outstanding-line credits and downstream FIFO space, which keeps the display DMA FIFO fed without overflow.
- Sits between the frame-buffer writer status and the display DMA read channel, upstream of the 2x upscaler and display FIFO.

Parameters:
- FRAME_WIDTH, 540, source line width in pixels (even); 2 px per 64-bit beat.
- FRAME_HEIGHT, 540, source lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of buffer 0.
- FRAME_BYTES, FRAME_WIDTH*FRAME_HEIGHT*4, byte stride between buffers.
- NUM_BUFS, 3, frame buffers in rotation (2..4).
- MAX_OUTSTANDING, 2, max lines issued but not yet completed (1..7).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, level; scheduler may start new frames only when high.
- frame_start, input, 1, one-cycle pulse at display vsync falling edge.
- wr_buf_valid, input, 1, level; at least one complete buffer exists.
- wr_buf_idx, input, 2, index of last completed written buffer.
- space_ok, input, 1, downstream FIFO can absorb one more line.
- cmd_valid, output, 1, DMA read command valid.
- cmd_ready, input, 1, DMA accepts command.
- cmd_addr, output, 32, line start byte address.
- cmd_len, output, 16, beats per line = FRAME_WIDTH/2.
- line_done, input, 1, pulse: one issued line fully returned.
- busy, output, 1, frame in progress.
- rd_buf_idx, output, 2, buffer being read.
- line_cnt, output, 12, lines issued in current frame.
- frame_cnt, output, 16, frames completed (wraps).
- err_frame_late, output, 1, sticky: frame_start while busy.
- err_no_buffer, output, 1, sticky: frame_start, enable high, wr_buf_valid low.

Behaviour:
- Reset values:
  - All outputs 0, except cmd_len, which is the constant FRAME_WIDTH/2.
  - State IDLE; outstanding count 0.
- FSM states: IDLE, ISSUE, WAIT_CREDIT, DRAIN.
- IDLE:
  - On frame_start & enable & wr_buf_valid: latch rd_buf_idx <= wr_buf_idx; load addr <= BASE_ADDR + wr_buf_idx*FRAME_BYTES; line_cnt <= 0; busy <= 1; go to ISSUE next cycle.
  - On frame_start & enable & ~wr_buf_valid: set err_no_buffer; stay IDLE.
  - frame_start with enable low is ignored.
- ISSUE:
  - cmd_valid=1 when outstanding < MAX_OUTSTANDING and space_ok; otherwise go to WAIT_CREDIT with cmd_valid=0.
  - Once cmd_valid is high, hold cmd_valid and cmd_addr stable until cmd_ready, regardless of space_ok or credit changes.
  - On the handshake: addr += FRAME_WIDTH*4; line_cnt += 1; outstanding += 1.
  - If this handshake issued line FRAME_HEIGHT-1, go to DRAIN.
- WAIT_CREDIT: return to ISSUE on the cycle the condition becomes true; cmd_valid asserts on the following cycle (1-cycle latency).
- DRAIN:
  - Wait for outstanding == 0, then frame_cnt += 1, busy <= 0, go to IDLE.
  - A frame_start in the same cycle as the DRAIN exit is treated as late (err_frame_late); it does not start a frame.
- Outstanding count:
  - Same-cycle handshake and line_done leaves the count unchanged.
  - line_done at outstanding == 0 is ignored (no underflow).
- frame_start while busy: set err_frame_late; current frame continues; no restart.
- enable deasserted mid-frame: current frame completes; the next frame_start is ignored.
- Address arithmetic: 32-bit, wraps modulo 2^32. Buffer offset is computed by repeated add over a constant table, with no multiplier in the issue path.
- wr_buf_idx >= NUM_BUFS: treated as err_no_buffer.
- Sticky errors clear only on rst.

Decomposition:
- Package display_sched_pkg holds:
  - FSM state enum.
  - LINE_BEATS, LINE_BYTES and the BUF_BASE table (NUM_BUFS entries).
  - Width constants.
- Natural sub-module: display_sched_credit_cnt, the outstanding-line up/down counter with saturation guard and credit_ok output.

Test Plan:
- Nominal frame, FRAME_WIDTH=8, FRAME_HEIGHT=4, cmd_ready=1, space_ok=1, line_done 3 cycles after each handshake, wr_buf_idx=1, FRAME_BYTES=128 -> cmd_addr 128,160,192,224; cmd_len=4; frame_cnt=1; busy low after the last line_done.
- Credit limit, MAX_OUTSTANDING=2, line_done withheld -> exactly 2 commands issued, cmd_valid low until the first line_done, then the third command appears one cycle later.
- Backpressure: cmd_ready low 5 cycles with space_ok toggling -> cmd_valid and cmd_addr stable throughout, single handshake, line_cnt +1.
- frame_start mid-frame -> err_frame_late=1, rd_buf_idx unchanged, frame finishes with 4 lines.
- frame_start with wr_buf_valid=0 -> err_no_buffer=1, no cmd_valid; a later frame_start with valid buffer 2 -> first cmd_addr=256.
- Async rst asserted during ISSUE with 1 outstanding -> all outputs 0 immediately; a later line_done is ignored; the next frame starts cleanly.
